// File: rtl/stack_seq.sv
// Instruction sequencer for the stack CPU. It fetches and decodes instructions and turns each
// one into spaced single-cycle stack strobes. It also tracks stack occupancy for overflow and underflow.
module stack_seq #(
  parameter int WORD  = 4,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [WORD-1:0] imem_addr,
  input  logic [WORD+3:0] imem_data,
  input  logic [WORD-1:0] stk_peak,
  output logic [WORD-1:0] stk_din,
  output logic            stk_push,
  output logic            stk_pop,
  output logic [WORD-1:0] alu_a,
  output logic [WORD-1:0] alu_b,
  output logic [2:0]      alu_s,
  input  logic [WORD-1:0] alu_result,
  output logic            busy,
  output logic            halted,
  output logic            err_ovf,
  output logic            err_unf
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, PUSH, POP_B, GAP, POP_A, EXEC, HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_PUSHI = 4'd1,
    OP_DROP  = 4'd2,
    OP_ALU   = 4'd3,
    OP_JZ    = 4'd4,
    OP_JMP   = 4'd5,
    OP_DUP   = 4'd6,
    OP_HALT  = 4'd15
  } opcode_t;

  state_t          state;
  logic [WORD-1:0] pc;
  logic [CW-1:0]   count;
  logic [3:0]      ir_op;

  logic [3:0]      op;
  logic [WORD-1:0] imm;
  int              need;
  logic            full;
  logic [CW-1:0]   count_push;

  function automatic logic is_unary(input logic [2:0] s);
    return (s == 3'd3) || (s == 3'd6) || (s == 3'd7);
  endfunction

  assign op        = imem_data[WORD+3:WORD];
  assign imm       = imem_data[WORD-1:0];
  assign imem_addr = pc;

  // A push at full occupancy leaves the count pinned and raises the sticky overflow flag.
  assign full       = (count == CW'(DEPTH));
  assign count_push = full ? count : count + 1'b1;

  always_comb begin
    need = 0;
    case (op)
      OP_DROP, OP_JZ, OP_DUP: need = 1;
      OP_ALU:                 need = is_unary(imm[2:0]) ? 1 : 2;
      default:                need = 0;
    endcase
  end

  // NOTE: every register here is assigned with <= so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= '0;
      count    <= '0;
      ir_op    <= '0;
      stk_din  <= '0;
      stk_push <= 1'b0;
      stk_pop  <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_s    <= '0;
      busy     <= 1'b0;
      halted   <= 1'b0;
      err_ovf  <= 1'b0;
      err_unf  <= 1'b0;
    end else begin
      // NOTE: strobes default low so each is high for exactly one cycle.
      stk_push <= 1'b0;
      stk_pop  <= 1'b0;

      case (state)
        IDLE, HALT: begin
          if (start) begin
            pc      <= '0;
            count   <= '0;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
            halted  <= 1'b0;
            busy    <= 1'b1;
            state   <= FETCH;
          end
        end

        FETCH: state <= DECODE;

        DECODE: begin
          ir_op <= op;
          pc    <= pc + 1'b1;
          // Operand check comes before any strobe so the stack is never popped past empty.
          if (int'(count) < need) begin
            err_unf <= 1'b1;
            halted  <= 1'b1;
            busy    <= 1'b0;
            state   <= HALT;
          end else begin
            case (op)
              OP_PUSHI, OP_DUP: begin
                stk_din  <= (op == OP_PUSHI) ? imm : stk_peak;
                stk_push <= 1'b1;
                count    <= count_push;
                err_ovf  <= err_ovf | full;
                state    <= PUSH;
              end
              OP_DROP, OP_ALU: begin
                if (op == OP_ALU) alu_s <= imm[2:0];
                stk_pop <= 1'b1;
                count   <= count - 1'b1;
                state   <= POP_B;
              end
              OP_JZ: begin
                if (stk_peak == '0) pc <= imm;
                state <= FETCH;
              end
              OP_JMP: begin
                pc    <= imm;
                state <= FETCH;
              end
              OP_HALT: begin
                busy   <= 1'b0;
                halted <= 1'b1;
                state  <= HALT;
              end
              default: state <= FETCH;
            endcase
          end
        end

        // Peak is read while the pop is strobed: the prior cycle was strobe-free, so it is settled.
        POP_B: begin
          if (ir_op == OP_DROP) begin
            state <= FETCH;
          end else begin
            alu_b <= stk_peak;
            state <= is_unary(alu_s) ? EXEC : GAP;
          end
        end

        GAP: begin
          stk_pop <= 1'b1;
          count   <= count - 1'b1;
          state   <= POP_A;
        end

        POP_A: begin
          alu_a <= stk_peak;
          state <= EXEC;
        end

        EXEC: begin
          stk_din  <= alu_result;
          stk_push <= 1'b1;
          count    <= count_push;
          err_ovf  <= err_ovf | full;
          state    <= PUSH;
        end

        PUSH: state <= FETCH;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_seq.sv
// Directed bench for stack_seq: program memory, a two-entry stack and an ALU are modelled around the DUT.
module tb_stack_seq;

  typedef logic [15:0][7:0] prog_t;

  typedef struct {
    string       name;
    prog_t       prog;
    logic        halted_e;
    logic        ovf_e;
    logic        unf_e;
    logic [3:0]  peak_e;
    int          pushes_e;
    int          pops_e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] imem_addr;
  logic [7:0] imem_data;
  logic [3:0] stk_peak;
  logic [3:0] stk_din;
  logic       stk_push, stk_pop;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_s;
  logic [3:0] alu_result;
  logic       busy, halted, err_ovf, err_unf;

  logic [7:0] mem [16];
  logic [3:0] stk_top, stk_bot;
  int         push_cnt, pop_cnt;
  int         viol = 0;
  logic       prev_push = 1'b0, prev_pop = 1'b0;
  int         n_vec = 0, n_bad = 0;
  vec_t       vecs [13];
  logic [24:0] all_out;

  stack_seq #(.WORD(4), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .stk_peak(stk_peak), .stk_din(stk_din), .stk_push(stk_push), .stk_pop(stk_pop),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_result(alu_result),
    .busy(busy), .halted(halted), .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= mem[imem_addr];

  // Two-entry stack: a push when full drops the bottom entry.
  always @(posedge clk) begin
    if (rst) begin
      stk_top <= '0; stk_bot <= '0;
    end else if (stk_push) begin
      stk_top <= stk_din; stk_bot <= stk_top;
    end else if (stk_pop) begin
      stk_top <= stk_bot; stk_bot <= '0;
    end
  end
  assign stk_peak = stk_top;

  function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
    case (s)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~b;
      3'd4: return a + b;
      3'd5: return a - b;
      3'd6: return b + 4'd1;
      default: return b >> 1;
    endcase
  endfunction
  assign alu_result = alu_f(alu_a, alu_b, alu_s);

  always @(posedge clk) begin
    if (rst) begin
      push_cnt <= 0; pop_cnt <= 0;
    end else begin
      if (stk_push) push_cnt <= push_cnt + 1;
      if (stk_pop)  pop_cnt  <= pop_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (stk_push && stk_pop)   viol++;
    if (stk_push && prev_push) viol++;
    if (stk_pop && prev_pop)   viol++;
    prev_push = stk_push;
    prev_pop  = stk_pop;
  end

  assign all_out = {imem_addr, stk_din, stk_push, stk_pop, alu_a, alu_b, alu_s,
                    busy, halted, err_ovf, err_unf};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic load(input prog_t p);
    for (int i = 0; i < 16; i++) mem[i] = p[i];
  endtask

  // Leaves the bench sampling in the FETCH cycle of pc 0.
  task automatic kick();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  function automatic prog_t prog4(input logic [7:0] a, input logic [7:0] b,
                                  input logic [7:0] c, input logic [7:0] d);
    prog_t p = '0;
    p[0] = a; p[1] = b; p[2] = c; p[3] = d;
    return p;
  endfunction

  function automatic vec_t mk(input string n, input prog_t p, input logic h, input logic o,
                              input logic u, input logic [3:0] pk, input int pu, input int po);
    vec_t v;
    v.name = n; v.prog = p; v.halted_e = h; v.ovf_e = o; v.unf_e = u;
    v.peak_e = pk; v.pushes_e = pu; v.pops_e = po;
    return v;
  endfunction

  initial begin
    prog_t p;
    int    waited;

    vecs[0]  = mk("add",        prog4(8'h13, 8'h15, 8'h34, 8'hF0), 1, 0, 0, 4'h8, 3, 2);
    vecs[1]  = mk("overflow",   prog4(8'h11, 8'h12, 8'h13, 8'hF0), 1, 1, 0, 4'h3, 3, 0);
    vecs[2]  = mk("drop_unf",   prog4(8'h20, 8'hF0, 8'hF0, 8'hF0), 1, 0, 1, 4'h0, 0, 0);
    vecs[3]  = mk("unary_not",  prog4(8'h16, 8'h33, 8'hF0, 8'hF0), 1, 0, 0, 4'h9, 2, 1);
    vecs[4]  = mk("sub",        prog4(8'h17, 8'h12, 8'h35, 8'hF0), 1, 0, 0, 4'h5, 3, 2);
    p = prog4(8'h10, 8'h49, 8'h1F, 8'hF0); p[9] = 8'hF0;
    vecs[5]  = mk("jz_taken",   p, 1, 0, 0, 4'h0, 1, 0);
    p = prog4(8'h11, 8'h49, 8'h1A, 8'hF0); p[9] = 8'hF0;
    vecs[6]  = mk("jz_not",     p, 1, 0, 0, 4'hA, 2, 0);
    vecs[7]  = mk("bin_unf",    prog4(8'h11, 8'h34, 8'hF0, 8'hF0), 1, 0, 1, 4'h1, 1, 0);
    p = prog4(8'h53, 8'h1F, 8'hF0, 8'h14); p[4] = 8'hF0;
    vecs[8]  = mk("jmp",        p, 1, 0, 0, 4'h4, 1, 0);
    vecs[9]  = mk("drop",       prog4(8'h11, 8'h12, 8'h20, 8'hF0), 1, 0, 0, 4'h1, 2, 1);
    vecs[10] = mk("unary_full", prog4(8'h11, 8'h12, 8'h36, 8'hF0), 1, 0, 0, 4'h3, 3, 1);
    vecs[11] = mk("nop_range",  prog4(8'h13, 8'h70, 8'hE5, 8'hF0), 1, 0, 0, 4'h3, 1, 0);
    vecs[12] = mk("dup_add",    prog4(8'h15, 8'h60, 8'h34, 8'hF0), 1, 0, 0, 4'hA, 3, 2);

    // Reset state, then the add program followed cycle by cycle.
    load(vecs[0].prog);
    do_reset();
    check("reset_outputs", 32'(all_out), 32'h0);
    kick();
    check("start_busy", {31'h0, busy}, 32'h1);
    check("start_addr", 32'(imem_addr), 32'h0);
    step(11);
    check("exec_operands", 32'({alu_a, alu_b, alu_s}), 32'({4'd3, 4'd5, 3'd4}));
    step(1);
    check("exec_push", 32'({stk_push, stk_din}), 32'({1'b1, 4'd8}));
    step(3);
    check("add_halted", 32'({halted, busy}), 32'b10);

    // Underflow halts two cycles after start without any pop.
    load(prog4(8'h20, 8'h00, 8'h00, 8'h00));
    do_reset();
    kick();
    step(1);
    check("unf_not_yet", {31'h0, halted}, 32'h0);
    step(1);
    check("unf_halt", 32'({halted, busy, err_unf}), 32'b101);
    check("unf_no_pop", 32'(pop_cnt), 32'h0);

    // JZ taken on zero: the next fetch is at the target.
    p = prog4(8'h10, 8'h49, 8'h00, 8'h00);
    load(p);
    do_reset();
    kick();
    step(3);
    check("jz_fetch_pc1", 32'(imem_addr), 32'h1);
    step(2);
    check("jz_target", 32'(imem_addr), 32'h9);

    // JMP 15 then NOP at 15: pc wraps to 0.
    p = '0; p[0] = 8'h5F; p[15] = 8'h00;
    load(p);
    do_reset();
    kick();
    step(2);
    check("jmp_target", 32'(imem_addr), 32'hF);
    step(2);
    check("pc_wrap", 32'(imem_addr), 32'h0);

    // Reset during GAP of a binary op: no result push afterwards.
    load(vecs[0].prog);
    do_reset();
    kick();
    step(9);
    check("gap_no_strobe", 32'({stk_push, stk_pop}), 32'h0);
    rst = 1'b1;
    step(1);
    check("gap_reset_out", 32'(all_out), 32'h0);
    rst = 1'b0;
    step(8);
    check("gap_no_push", 32'(push_cnt), 32'h0);
    check("gap_idle", 32'({busy, halted}), 32'h0);

    // Table-driven programs, each run to completion.
    for (int i = 0; i < 13; i++) begin
      load(vecs[i].prog);
      do_reset();
      kick();
      waited = 0;
      while (!halted && waited < 300) begin
        step(1);
        waited++;
      end
      check({vecs[i].name, "_halted"}, 32'({halted, busy}), 32'({vecs[i].halted_e, 1'b0}));
      check({vecs[i].name, "_errs"}, 32'({err_ovf, err_unf}), 32'({vecs[i].ovf_e, vecs[i].unf_e}));
      check({vecs[i].name, "_peak"}, 32'(stk_peak), 32'(vecs[i].peak_e));
      check({vecs[i].name, "_pushes"}, 32'(push_cnt), 32'(vecs[i].pushes_e));
      check({vecs[i].name, "_pops"}, 32'(pop_cnt), 32'(vecs[i].pops_e));
    end

    // start while busy is ignored: restarting mid-program must not reset pc.
    load(vecs[0].prog);
    do_reset();
    kick();
    step(2);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("start_ignored", 32'(imem_addr), 32'h1);

    check("strobe_protocol", 32'(viol), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/stack_seq.md
# stack_seq

Instruction sequencer for the stack CPU. Fetches instructions from a synchronous-read program memory, decodes them, and drives the `stack` block's `din`/`push`/`pop` strobes and the `alu` block's operands and select. It sits directly upstream of both and turns each instruction into a spaced sequence of single-cycle stack strobes. It also tracks stack occupancy so overflow and underflow are detected here, since the stack itself cannot report them.

## Interface
- `WORD`, 4: data width; also the PC width and the immediate width.
- `DEPTH`, 2: stack depth; occupancy counter saturates here.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: run request, sampled only when not busy.
- `imem_addr` out WORD: program address (registered).
- `imem_data` in WORD+4: instruction; valid one cycle after `imem_addr`.
  - opcode = [WORD+3:WORD]
  - imm = [WORD-1:0]
- `stk_peak` in WORD: top of stack.
- `stk_din` out WORD: value to push.
- `stk_push` out 1: push strobe, one cycle wide.
- `stk_pop` out 1: pop strobe, one cycle wide.
- `alu_a` out WORD, `alu_b` out WORD, `alu_s` out 3: ALU operands and select (registered).
- `alu_result` in WORD: combinational ALU output.
- `busy` out 1: executing.
- `halted` out 1: stopped by HALT or underflow.
- `err_ovf` out 1: sticky; a push occurred at full occupancy.
- `err_unf` out 1: sticky; an operand was needed from an under-occupied stack.

## Operation
- States:
  - IDLE: reached after reset.
  - FETCH, DECODE.
  - Op states: PUSH, POP_B, GAP, POP_A, EXEC.
  - HALT.
- IDLE/HALT + `start`=1:
  - pc, occupancy count and error flags cleared to 0.
  - `halted`=0, `busy`=1, go to FETCH.
- FETCH: `imem_addr`=pc.
- DECODE: latch `imem_data`; pc <= pc+1, wrapping mod 2^WORD.
- Opcodes:
  - 0 NOP: back to FETCH.
  - 1 PUSHI: push imm.
  - 2 DROP: pop.
  - 3 ALU: `alu_s`=imm[2:0].
    - S in {3,6,7} is unary: pop B, push f(B).
    - Otherwise binary: pop B, then pop A, push f(A,B).
  - 4 JZ: if peak==0 then pc <= imm; no pop.
  - 5 JMP: pc <= imm.
  - 6 DUP: push peak.
  - 15 HALT.
  - 7–14: treated as NOP.
- Occupancy count:
  - +1 per push, saturating at DEPTH.
  - −1 per pop.
  - Push at count==DEPTH: the stack drops its bottom entry, count stays DEPTH, `err_ovf`=1, execution continues.
- Operand check in DECODE, before any strobe:
  - Required operands: DROP/JZ/DUP/unary = 1; binary = 2.
  - If count < required: no strobe issued, `err_unf`=1, go to HALT.
- HALT: `busy`=0, `halted`=1. Stays there until `start`.
- Reset values:
  - All outputs 0.
  - pc=0, count=0, state IDLE.
- `start` is ignored while `busy`.

## Timing
- Cycle F: FETCH. Cycle D = F+1: DECODE. All outputs are registered.
- PUSHI/DUP:
  - D+1: `stk_push`=1, `stk_din`=imm or peak.
  - D+2: next FETCH.
- DROP:
  - D+1: `stk_pop`=1.
  - D+2: FETCH.
- NOP/JMP/JZ: D+1 is FETCH of the new pc.
- Unary ALU:
  - D+1: `alu_b`<=peak, `stk_pop`=1.
  - D+2: EXEC; `alu_result` captured.
  - D+3: `stk_push`=1, `stk_din`=result.
  - D+4: FETCH.
- Binary ALU:
  - D+1: B<=peak, `stk_pop`=1.
  - D+2: GAP, all strobes 0.
  - D+3: A<=peak, `stk_pop`=1.
  - D+4: EXEC.
  - D+5: push result.
  - D+6: FETCH.
- `stk_peak` is sampled only in a cycle whose previous cycle carried no strobe, or after a full settle cycle.
- Strobe rules:
  - Never two consecutive high cycles on the same strobe.
  - `stk_push` and `stk_pop` are never high in the same cycle.
- Reset mid-instruction: strobes are 0 from the next edge. No partial ALU push.

## Test plan
- Reset check:
  - Stimulus: assert `rst` for 2 cycles.
  - Required: all outputs 0 and `imem_addr`=0; `start` then gives FETCH at pc 0 on the next cycle.
- Binary add:
  - Program: PUSHI 3, PUSHI 5, ALU(4), HALT.
  - Required: `alu_a`=3, `alu_b`=5, `alu_s`=4 in EXEC; then `stk_push` with `stk_din`=8; `halted`=1, `busy`=0.
- Overflow:
  - Program: PUSHI 1, PUSHI 2, PUSHI 3, HALT, with DEPTH=2.
  - Required: `err_ovf`=1 after the third push; all three pushes strobed; `halted`=1.
- Underflow:
  - Program: DROP at pc 0.
  - Required: no `stk_pop` pulse, `err_unf`=1, `halted`=1 two cycles after start.
- Jumps and wrap:
  - PUSHI 0, JZ 9: next `imem_addr`=9.
  - JMP 15, with NOP at 15: next `imem_addr`=0.
- Strobe protocol and reset:
  - Monitor across all programs: no back-to-back pulses on the same strobe, never push and pop together.
  - Assert `rst` during GAP of a binary op: no push follows, all outputs 0.
